// File: rtl/div11_seq.sv
// Sequential unsigned divide-by-11: one radix-4 digit per cycle from a 6-bit {r,d} lookup.
// Optional remainder output port enabled by defining DIV11_REM_OUT_EN.
module div11_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot
`ifdef DIV11_REM_OUT_EN
    ,
    output logic [3:0]       out_rem
`endif
);

    localparam int unsigned CW = $clog2(WIDTH / 2 + 1);
    localparam logic [CW-1:0] STEPS = CW'(WIDTH / 2);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sreg;
    logic [3:0]       r;
    logic [CW-1:0]    cnt;
    logic [5:0]       step;

    // With r <= 10, {r,d} read as a 6-bit number is already 4*r+d (0..43).
    function automatic logic [5:0] step_lut(input logic [5:0] t);
        logic [1:0] q;
        logic [5:0] rem;
        if (t >= 6'd33) begin
            q   = 2'd3;
            rem = t - 6'd33;
        end else if (t >= 6'd22) begin
            q   = 2'd2;
            rem = t - 6'd22;
        end else if (t >= 6'd11) begin
            q   = 2'd1;
            rem = t - 6'd11;
        end else begin
            q   = 2'd0;
            rem = t;
        end
        return {q, rem[3:0]};
    endfunction

    always_comb begin
        step = step_lut({r, sreg[WIDTH-1 -: 2]});
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = BUSY;
            end
            BUSY: begin
                if (cnt == CW'(1)) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Dividend bits leave at the MSB end while quotient digits enter at the LSB end,
    // so after WIDTH/2 steps sreg holds exactly the quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            r    <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg <= in_data;
                        r    <= '0;
                        cnt  <= STEPS;
                    end
                end
                BUSY: begin
                    sreg <= {sreg[WIDTH-3:0], step[5:4]};
                    r    <= step[3:0];
                    cnt  <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_quot = sreg;
`ifdef DIV11_REM_OUT_EN
    assign out_rem  = r;
`endif

endmodule

// File: tb/tb_div11_seq.sv
// Scoreboard bench for div11_seq: directed dividends with hand-computed quotient/remainder.
// Build with or without DIV11_REM_OUT_EN; remainder is checked only when the port exists.
module tb_div11_seq;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quot;
`ifdef DIV11_REM_OUT_EN
    logic [3:0]   out_rem;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [3:0]   r;
    } exp_t;

    exp_t sb[$];

    div11_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_quot (out_quot)
`ifdef DIV11_REM_OUT_EN
        ,
        .out_rem  (out_rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a result transfers on the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: actual quot=%0h required none", out_quot);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quot", out_quot, e.q);
`ifdef DIV11_REM_OUT_EN
                check("rem", W'(out_rem), W'(e.r));
`endif
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] q, input logic [3:0] r);
        exp_t e;
        e.q = q;
        e.r = r;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [W-1:0] d, input logic [W-1:0] q, input logic [3:0] r);
        int n;
        n = 0;
        push_exp(q, r);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: actual in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    task automatic wait_done(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, W'(lat), W'(W / 2));
    endtask

    logic [W-1:0] vec_d[9];
    logic [W-1:0] vec_q[9];
    logic [3:0]   vec_r[9];

    initial begin
        logic [W-1:0] q0;
        logic [3:0]   r0;

        vec_d[0] = 64'd0;                    vec_q[0] = 64'd0;                  vec_r[0] = 4'd0;
        vec_d[1] = 64'd10;                   vec_q[1] = 64'd0;                  vec_r[1] = 4'd10;
        vec_d[2] = 64'd11;                   vec_q[2] = 64'd1;                  vec_r[2] = 4'd0;
        vec_d[3] = 64'hFFFF_FFFF_FFFF_FFFF;  vec_q[3] = 64'h1745_D174_5D17_45D1; vec_r[3] = 4'd4;
        vec_d[4] = 64'd43;                   vec_q[4] = 64'd3;                  vec_r[4] = 4'd10;
        vec_d[5] = 64'd121;                  vec_q[5] = 64'd11;                 vec_r[5] = 4'd0;
        vec_d[6] = 64'd1000000;              vec_q[6] = 64'd90909;              vec_r[6] = 4'd1;
        vec_d[7] = 64'd4294967296;           vec_q[7] = 64'd390451572;          vec_r[7] = 4'd4;
        vec_d[8] = 64'h8000_0000_0000_0000;  vec_q[8] = 64'd838488366986797800; vec_r[8] = 4'd8;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_quot", out_quot, '0);
`ifdef DIV11_REM_OUT_EN
        check("rst_rem", W'(out_rem), '0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First dividend accepted on the first edge after reset release.
        issue(64'd100, 64'd9, 4'd1);
        check("accept_first_edge", W'(in_ready), W'(0));
        wait_done("latency_100");
        @(posedge clk);
        #1;
        check("idle_after_done_ready", W'(in_ready), W'(1));
        check("idle_after_done_valid", W'(out_valid), W'(0));

        for (int i = 0; i < 9; i++) begin
            issue(vec_d[i], vec_q[i], vec_r[i]);
            wait_done("latency_vec");
            @(posedge clk);
            #1;
        end

        // Backpressure: hold out_ready low for 10 cycles with a stray in_valid pulse.
        out_ready = 1'b0;
        issue(64'd2025, 64'd184, 4'd1);
        wait_done("latency_stall");
        q0 = out_quot;
`ifdef DIV11_REM_OUT_EN
        r0 = out_rem;
`else
        r0 = 4'd0;
`endif
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                in_data  = 64'd999;
            end
            if (i == 5) in_valid = 1'b0;
            check("stall_valid", W'(out_valid), W'(1));
            check("stall_in_ready", W'(in_ready), W'(0));
            check("stall_quot", out_quot, q0);
`ifdef DIV11_REM_OUT_EN
            check("stall_rem", W'(out_rem), W'(r0));
`endif
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (40) @(posedge clk);
        #1;
        check("stray_ignored_valid", W'(out_valid), W'(0));
        check("stray_ignored_ready", W'(in_ready), W'(1));

        // Reset in the middle of an operation discards it.
        issue(64'd100, 64'd9, 4'd1);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_quot", out_quot, '0);
        sb.delete();
        push_exp(64'd1122, 4'd3);
        in_valid = 1'b1;
        in_data  = 64'd12345;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("postrst_accept", W'(in_ready), W'(0));
        wait_done("latency_postrst");
        @(posedge clk);
        #1;

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", W'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual time=%0t required finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div11_seq.md
DIV11_SEQ -- requirements
Module: div11_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64: dividend and quotient width in bits; legal values are even and 4..128.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream presents a dividend.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a dividend.
REQ-006 SHALL have port in_data, input, WIDTH bits: unsigned dividend.
REQ-007 SHALL have port out_valid, output, 1 bit: result is available.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-009 SHALL have port out_quot, output, WIDTH bits: floor(in_data/11).
REQ-010 SHALL have port out_rem, output, 4 bits: in_data mod 11, range 0..10; present only when DIV11_REM_OUT_EN is defined.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE.
REQ-013 SHALL drive out_valid=1 only in DONE.
REQ-014 SHALL accept a dividend on an edge where in_valid=1 and in_ready=1: capture in_data into the shift register, clear the partial remainder r to 0, load the step counter with WIDTH/2, and go to BUSY.
REQ-015 SHALL process one radix-4 step per BUSY edge:
- t = 4*r + next two dividend MSBs (t in 0..43)
- quotient digit = floor(t/11), shifted into the quotient LSBs
- r <= t mod 11
REQ-016 SHALL compute each step from one 6-bit lookup: {r[3:0], d[1:0]} to {q[1:0], r'[3:0]}; there SHALL be no carry chain wider than 6 bits per step.
REQ-017 SHALL make the step counter decrement once per BUSY edge and go to DONE on the edge that completes step WIDTH/2; out_valid SHALL rise exactly WIDTH/2 edges after the accepting edge (32 for WIDTH=64).
REQ-018 SHALL hold out_quot and out_rem stable while out_valid=1 and out_ready=0.
REQ-019 SHALL go from DONE to IDLE on an edge with out_ready=1; no new dividend is accepted on that same edge, so the minimum initiation interval is WIDTH/2+2 cycles.
REQ-020 SHALL ignore in_valid in BUSY and DONE; in_data SHALL not be sampled outside acceptance.
REQ-021 SHALL keep r within 0..10 at all times.
REQ-022 SHALL produce a correct result for every dividend, including 0 and 2^WIDTH-1.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously force IDLE, in_ready=1, out_valid=0, out_quot=0, out_rem=0, counter=0 and r=0.
REQ-024 SHALL discard any in-flight operation when reset is asserted in BUSY or DONE; no partial result SHALL appear after reset is released.
REQ-025 SHALL accept its first dividend on the first rising edge after rst_n is deasserted.

Configuration
REQ-026 SHALL use macro DIV11_REM_OUT_EN.
- Defined: out_rem port exists and shows the final r, registered with out_quot.
- Undefined: out_rem port is absent; the final remainder is not stored; out_quot behaviour and latency are unchanged.

Verification
REQ-027 SHALL cover: in_data=100, out_ready=1 -> after 32 edges out_quot=9, out_rem=1; next edge in_ready=1.
REQ-028 SHALL cover: in_data=64'hFFFF_FFFF_FFFF_FFFF -> out_quot=64'h1745_D174_5D17_45D1, out_rem=4.
REQ-029 SHALL cover: in_data=0, 10, 11 -> (quot, rem) = (0,0), (0,10), (1,0) respectively.
REQ-030 SHALL cover: out_ready held 0 for 10 cycles after out_valid rises -> outputs stable, in_ready=0 throughout, and a new in_valid pulse is ignored.
REQ-031 SHALL cover: rst_n pulsed low at step 15 of an operation -> in_ready=1 and out_valid=0 immediately; the next dividend, 12345, yields 1122 rem 3.
REQ-032 SHALL cover: 10^5 random dividends with random valid/ready stalls, compared against a reference model, with the build run both with and without DIV11_REM_OUT_EN -> zero mismatches.
